// File: rtl/bsg_link_ddr_pkg.sv
// Shared definitions for the DDR link receive path: defaults, beat classification
// and the beat/channel-to-word bit mapping.
package bsg_link_ddr_pkg;

  localparam int unsigned WIDTH_DEFAULT         = 64;
  localparam int unsigned CHANNEL_WIDTH_DEFAULT = 8;
  localparam int unsigned NUM_CHANNELS_DEFAULT  = 2;
  localparam int unsigned LG_FIFO_DEPTH_DEFAULT = 2;
  localparam int unsigned LG_DECIMATION_DEFAULT = 1;

  typedef enum logic [1:0] {
    BEAT_IDLE,
    BEAT_ACCEPT,
    BEAT_LANE_ERR
  } beat_kind_e;

  function automatic int unsigned beats_per_word(input int unsigned width,
                                                 input int unsigned num_channels,
                                                 input int unsigned channel_width);
    return width / (num_channels * channel_width);
  endfunction

  function automatic int unsigned pack_index(input int unsigned beat,
                                             input int unsigned chan,
                                             input int unsigned bit_pos,
                                             input int unsigned num_channels,
                                             input int unsigned channel_width);
    return beat * num_channels * channel_width + chan * channel_width + bit_pos;
  endfunction

endpackage

// File: rtl/bsg_link_ddr_downstream_model_if.sv
// Link-side and core-side signals of the DDR downstream receiver.
interface bsg_link_ddr_downstream_model_if
  import bsg_link_ddr_pkg::*;
#(
  parameter int unsigned width_p         = WIDTH_DEFAULT,
  parameter int unsigned channel_width_p = CHANNEL_WIDTH_DEFAULT,
  parameter int unsigned num_channels_p  = NUM_CHANNELS_DEFAULT
);
  logic [num_channels_p-1:0]                 io_valid_i;
  logic [num_channels_p*channel_width_p-1:0] io_data_i;
  logic                                      core_valid_o;
  logic [width_p-1:0]                        core_data_o;
  logic                                      core_yumi_i;
  logic [num_channels_p-1:0]                 token_clk_o;
  logic                                      error_o;

  modport master (
    output io_valid_i, io_data_i, core_yumi_i,
    input  core_valid_o, core_data_o, token_clk_o, error_o
  );

  modport slave (
    input  io_valid_i, io_data_i, core_yumi_i,
    output core_valid_o, core_data_o, token_clk_o, error_o
  );
endinterface

// File: rtl/bsg_link_ddr_rx_fifo.sv
// Receive word FIFO with wrap-bit pointers; enq and deq may fire in the same cycle.
// The caller only enqueues when not full (or popping) and only dequeues when not empty.
module bsg_link_ddr_rx_fifo
  import bsg_link_ddr_pkg::*;
#(
  parameter int unsigned width_p    = WIDTH_DEFAULT,
  parameter int unsigned lg_depth_p = LG_FIFO_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq,
  input  logic               deq,
  input  logic [width_p-1:0] wdata,
  output logic [width_p-1:0] rdata,
  output logic               full,
  output logic               empty
);
  localparam int unsigned PTR_W = lg_depth_p + 1;
  localparam int unsigned DEPTH = 1 << lg_depth_p;

  logic [PTR_W-1:0]   wptr, rptr;
  logic [width_p-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq) wptr <= wptr + PTR_W'(1);
      if (deq) rptr <= rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wptr[lg_depth_p-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[lg_depth_p-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                 (wptr[lg_depth_p-1:0] == rptr[lg_depth_p-1:0]);
endmodule

// File: rtl/bsg_link_ddr_downstream_model.sv
// DDR link receive end: assembles lockstep channel beats into core words, buffers them,
// and returns credit tokens as the core consumes words.
module bsg_link_ddr_downstream_model
  import bsg_link_ddr_pkg::*;
#(
  parameter int unsigned width_p                          = WIDTH_DEFAULT,
  parameter int unsigned channel_width_p                  = CHANNEL_WIDTH_DEFAULT,
  parameter int unsigned num_channels_p                   = NUM_CHANNELS_DEFAULT,
  parameter int unsigned lg_fifo_depth_p                  = LG_FIFO_DEPTH_DEFAULT,
  parameter int unsigned lg_credit_to_token_decimation_p  = LG_DECIMATION_DEFAULT
) (
  input logic clk,
  input logic rst_n,
  bsg_link_ddr_downstream_model_if.slave link
);
  localparam int unsigned BEAT_W = num_channels_p * channel_width_p;
  localparam int unsigned BEATS  = beats_per_word(width_p, num_channels_p, channel_width_p);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEC_W  = (lg_credit_to_token_decimation_p > 0) ?
                                   lg_credit_to_token_decimation_p : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'((1 << lg_credit_to_token_decimation_p) - 1);

  beat_kind_e         kind;
  logic [CNT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]  beat_q [BEATS-1];
  logic [width_p-1:0] word;
  logic [DEC_W-1:0]   dec_cnt;
  logic               token_r, err_r;
  logic               full, empty, last_beat, pop, enq, overflow, underflow;

  always_comb begin
    kind = BEAT_IDLE;
    if (&link.io_valid_i)      kind = BEAT_ACCEPT;
    else if (|link.io_valid_i) kind = BEAT_LANE_ERR;
  end

  assign last_beat = (kind == BEAT_ACCEPT) && (beat_cnt == LAST_BEAT);
  assign pop       = link.core_yumi_i && !empty;
  assign underflow = link.core_yumi_i && empty;
  // a full FIFO still takes the word when the head leaves on the same edge
  assign enq       = last_beat && (!full || pop);
  assign overflow  = last_beat && full && !pop;

  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < BEATS - 1; k++)
      word[pack_index(k, 0, 0, num_channels_p, channel_width_p) +: BEAT_W] = beat_q[k];
    word[pack_index(BEATS - 1, 0, 0, num_channels_p, channel_width_p) +: BEAT_W] = link.io_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      for (int unsigned k = 0; k < BEATS - 1; k++) beat_q[k] <= '0;
    end else if (kind == BEAT_ACCEPT) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      for (int unsigned k = 0; k < BEATS - 1; k++)
        if (beat_cnt == CNT_W'(k)) beat_q[k] <= link.io_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      token_r <= 1'b0;
    end else if (pop) begin
      if (dec_cnt == DEC_LAST) begin
        dec_cnt <= '0;
        token_r <= ~token_r;
      end else begin
        dec_cnt <= dec_cnt + DEC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_r <= 1'b0;
    else if ((kind == BEAT_LANE_ERR) || overflow || underflow) err_r <= 1'b1;
  end

  bsg_link_ddr_rx_fifo #(
    .width_p    (width_p),
    .lg_depth_p (lg_fifo_depth_p)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .enq   (enq),
    .deq   (pop),
    .wdata (word),
    .rdata (link.core_data_o),
    .full  (full),
    .empty (empty)
  );

  assign link.core_valid_o = !empty;
  assign link.token_clk_o  = {num_channels_p{token_r}};
  assign link.error_o      = err_r;
endmodule

// File: tb/tb_bsg_link_ddr_downstream_model.sv
// Self-checking bench: constant vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_bsg_link_ddr_downstream_model;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  bsg_link_ddr_downstream_model_if #(.width_p(64), .channel_width_p(8), .num_channels_p(2)) link();

  bsg_link_ddr_downstream_model dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  logic [63:0] mq[$];
  int          m_bc;
  logic [15:0] m_beats[4];
  bit          m_err;
  int          m_pops;
  bit          m_tok;

  task automatic model_reset();
    mq.delete();
    m_bc = 0; m_err = 0; m_pops = 0; m_tok = 0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [15:0] d, input logic y);
    bit          pop_ok;
    bit          push;
    logic [63:0] w;
    pop_ok = y && (mq.size() > 0);
    push   = 0;
    w      = '0;
    if (y && mq.size() == 0) m_err = 1;
    if (v == 2'b11) begin
      m_beats[m_bc] = d;
      if (m_bc == 3) begin
        for (int k = 0; k < 4; k++) w[k*16 +: 16] = m_beats[k];
        if (mq.size() < 4 || pop_ok) push = 1;
        else m_err = 1;
        m_bc = 0;
      end else begin
        m_bc++;
      end
    end else if (v != 2'b00) begin
      m_err = 1;
    end
    if (pop_ok) begin
      void'(mq.pop_front());
      m_pops++;
      if (m_pops % 2 == 0) m_tok = ~m_tok;
    end
    if (push) mq.push_back(w);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic ev, input logic [63:0] ed,
                           input logic ee, input logic [1:0] et);
    check({name, " valid"}, {63'd0, link.core_valid_o}, {63'd0, ev});
    if (ev) check({name, " data"}, link.core_data_o, ed);
    check({name, " error"}, {63'd0, link.error_o}, {63'd0, ee});
    check({name, " token"}, {62'd0, link.token_clk_o}, {62'd0, et});
  endtask

  task automatic model_check(input string name);
    check_out(name, mq.size() > 0, (mq.size() > 0) ? mq[0] : 64'd0, m_err, {2{m_tok}});
  endtask

  task automatic cyc(input logic [1:0] v, input logic [15:0] d, input logic y);
    link.io_valid_i  = v;
    link.io_data_i   = d;
    link.core_yumi_i = y;
    model_step(v, d, y);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    link.io_valid_i  = '0;
    link.io_data_i   = '0;
    link.core_yumi_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [63:0] w, input logic y_first, input logic y_last);
    for (int k = 0; k < 4; k++)
      cyc(2'b11, w[k*16 +: 16], (k == 0) ? y_first : ((k == 3) ? y_last : 1'b0));
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d;
    logic        y;
    logic        ev;
    logic [63:0] ed;
    logic        ee;
    logic [1:0]  et;
  } vec_t;

  vec_t        tbl[14];
  logic [63:0] words[6];

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    words[0] = 64'h0123_4567_89ab_cdef;
    words[1] = 64'hdead_beef_cafe_f00d;
    words[2] = 64'h1111_2222_3333_4444;
    words[3] = 64'h5a5a_a5a5_0f0f_f0f0;
    words[4] = 64'h8765_4321_fedc_ba98;
    words[5] = 64'h0bad_c0de_1234_5678;

    tbl[0]  = '{2'b11, 16'h1100, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[1]  = '{2'b11, 16'h3322, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[2]  = '{2'b11, 16'h5544, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[3]  = '{2'b11, 16'h7766, 1'b0, 1'b1, 64'h7766554433221100, 1'b0, 2'b00};
    tbl[4]  = '{2'b00, 16'h0000, 1'b1, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[5]  = '{2'b00, 16'hffff, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[6]  = '{2'b11, 16'haaaa, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[7]  = '{2'b11, 16'hbbbb, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[8]  = '{2'b00, 16'h1234, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[9]  = '{2'b00, 16'h5678, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[10] = '{2'b00, 16'h9abc, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[11] = '{2'b11, 16'hcccc, 1'b0, 1'b0, 64'd0, 1'b0, 2'b00};
    tbl[12] = '{2'b11, 16'hdddd, 1'b0, 1'b1, 64'hddddccccbbbbaaaa, 1'b0, 2'b00};
    tbl[13] = '{2'b00, 16'h0000, 1'b1, 1'b0, 64'd0, 1'b0, 2'b11};

    // table: single word, first pop, idle-gap word, second pop toggles tokens
    do_reset();
    check_out("reset", 1'b0, 64'd0, 1'b0, 2'b00);
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].y);
      check_out($sformatf("tbl[%0d]", i), tbl[i].ev, tbl[i].ed, tbl[i].ee, tbl[i].et);
    end

    // tokens: four words, each popped as the next one starts
    do_reset();
    for (int w = 0; w < 4; w++) begin
      send_word(words[w], (w > 0), 1'b0);
      check_out($sformatf("tok word%0d", w), 1'b1, words[w], 1'b0, {2{w[1]}});
    end
    cyc(2'b00, 16'h0, 1'b1);
    check_out("tok final", 1'b0, 64'd0, 1'b0, 2'b00);

    // full FIFO, fifth word without yumi overflows
    do_reset();
    for (int w = 0; w < 4; w++) send_word(words[w], 1'b0, 1'b0);
    check_out("full", 1'b1, words[0], 1'b0, 2'b00);
    send_word(words[4], 1'b0, 1'b0);
    check_out("overflow", 1'b1, words[0], 1'b1, 2'b00);

    // full FIFO, fifth word with same-cycle yumi is accepted
    do_reset();
    for (int w = 0; w < 4; w++) send_word(words[w], 1'b0, 1'b0);
    send_word(words[4], 1'b0, 1'b1);
    check_out("full+yumi", 1'b1, words[1], 1'b0, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d", i), link.core_data_o, words[i]);
      cyc(2'b00, 16'h0, 1'b1);
    end
    check_out("drained", 1'b0, 64'd0, 1'b0, 2'b00);

    // lane mismatch is ignored but flagged
    do_reset();
    cyc(2'b11, 16'h0a0a, 1'b0);
    cyc(2'b11, 16'h1b1b, 1'b0);
    cyc(2'b10, 16'hffff, 1'b0);
    check_out("mismatch", 1'b0, 64'd0, 1'b1, 2'b00);
    cyc(2'b11, 16'h2c2c, 1'b0);
    cyc(2'b11, 16'h3d3d, 1'b0);
    check_out("mismatch word", 1'b1, 64'h3d3d2c2c1b1b0a0a, 1'b1, 2'b00);

    // asynchronous reset mid-word with tokens, error and a buffered word
    do_reset();
    send_word(words[0], 1'b0, 1'b0);
    send_word(words[1], 1'b1, 1'b0);
    cyc(2'b00, 16'h0, 1'b1);
    cyc(2'b00, 16'h0, 1'b1);
    check_out("pre-reset", 1'b0, 64'd0, 1'b1, 2'b11);
    send_word(words[2], 1'b0, 1'b0);
    cyc(2'b11, words[3][15:0], 1'b0);
    cyc(2'b11, words[3][31:16], 1'b0);
    check_out("buffered", 1'b1, words[2], 1'b1, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async reset", 1'b0, 64'd0, 1'b0, 2'b00);
    link.io_valid_i  = '0;
    link.core_yumi_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_word(words[5], 1'b0, 1'b0);
    check_out("post-reset word", 1'b1, words[5], 1'b0, 2'b00);

    // randomized run against the reference model
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int n = 0; n < 500; n++) begin
        int          r;
        logic [1:0]  v;
        logic        y;
        r = $urandom_range(0, 999);
        if (r < 700) v = 2'b11;
        else if (r < 995 || blk < 2) v = 2'b00;
        else v = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        if (mq.size() > 0) y = ($urandom_range(0, 9) < ((blk == 1) ? 1 : 5));
        else y = (blk == 3) && ($urandom_range(0, 99) == 0);
        cyc(v, 16'($urandom), y);
        model_check($sformatf("rand b%0d n%0d", blk, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
